lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Sequential load/store unit for the NPC memory stage.
//  - Accepts one load or store per handshake from the EXU/WBU pipeline.
//  - Issues an aligned, byte-masked access to the data memory port and waits a variable number of cycles for it.
//  - Returns aligned, size-extended load data, or an error, on a valid/ready response channel.
//  - Generalises the single-cycle combinational LSU: access size and signedness, misalignment detection,
//    handshaking on both sides, and a bus timeout.
// PARAMETERS
//  XLEN       64   data width of core-side wdata/rdata; equals memory bus width
//  ADDR_W     64   address width
//  TIMEOUT    255  max cycles in WAIT before a timeout error is raised; 0 disables the timeout
// PORTS
//  clock          in   1       single clock; all state updates on rising edge
//  reset          in   1       synchronous, active-high
//  req_valid      in   1       core request valid
//  req_ready      out  1       LSU can accept a request
//  req_addr       in   ADDR_W  byte address
//  req_wen        in   1       1 = store, 0 = load
//  req_size       in   2       0 = B, 1 = H, 2 = W, 3 = D
//  req_signed     in   1       load result sign-extended (1) or zero-extended (0)
//  req_wdata      in   XLEN    store data, LSB-justified
//  resp_valid     out  1       response valid
//  resp_ready     in   1       core accepts response
//  resp_rdata     out  XLEN    extended load data; 0 for stores and errors
//  resp_err       out  1       misaligned access, bus error, or timeout
//  mem_req_valid  out  1       memory request valid
//  mem_req_ready  in   1       memory accepts request
//  mem_addr       out  ADDR_W  req_addr with bits [2:0] cleared
//  mem_wen        out  1       store
//  mem_wdata      out  XLEN    req_wdata << (addr[2:0]*8)
//  mem_wmask      out  8       size mask << addr[2:0]; 8'h00 for loads
//  mem_resp_valid in   1       memory response valid (one cycle pulse)
//  mem_rdata      in   XLEN    aligned 8-byte memory word
//  mem_resp_err   in   1       memory error, valid with mem_resp_valid
// BEHAVIOUR
//  - FSM states: IDLE, REQ, WAIT, RESP. Reset value is IDLE.
//  - Output reset values: req_ready = 1, resp_valid = 0, mem_req_valid = 0, resp_rdata = 0, resp_err = 0.
//    mem_* data, address and mask outputs are 0.
//  - IDLE: req_ready = 1.
//    - On req_valid & req_ready, latch addr, wen, size, signed and wdata.
//    - Misaligned access (addr % (1 << size) != 0): go to RESP with err = 1, rdata = 0. No memory access is made.
//    - Otherwise go to REQ.
//  - REQ: mem_req_valid = 1, with mem_* outputs driven from the latched request.
//    - On mem_req_ready, go to WAIT and clear the timeout counter.
//    - mem_req_valid and all mem_* outputs stay stable until accepted.
//  - WAIT: the timeout counter increments each cycle.
//    - On mem_resp_valid, latch err = mem_resp_err and go to RESP.
//    - rdata = sext/zext of (mem_rdata >> off*8) truncated to the access size. Stores and errors give rdata = 0.
//    - If TIMEOUT != 0 and the counter reaches TIMEOUT with no response, go to RESP with err = 1 and rdata = 0.
//    - A late mem_resp_valid that arrives after the timeout is ignored.
//  - RESP: resp_valid = 1, with rdata and err held stable.
//    - On resp_ready, go to IDLE. No back-to-back bypass: minimum one IDLE cycle between requests.
//  - Latency:
//    - Best case, with mem_req_ready=1 in REQ and a response 1 cycle after acceptance: resp_valid 3 cycles after the request handshake.
//    - Misaligned access: resp_valid 1 cycle after the request handshake.
//  - mem_resp_valid outside WAIT is ignored.
//  - Reset mid-operation: FSM goes to IDLE, the latched request and counter clear, and the outstanding memory transaction is abandoned.
//  - D-size store gives wmask 8'hFF. H at offset 6 gives wmask 8'hC0.
// TESTING
//  - LB signed at 0x8000_0003, mem_rdata = 64'h0000_0000_80FF_0000 -> resp_rdata = 64'hFFFF_FFFF_FFFF_FF80, err = 0.
//  - SH at 0x8000_0006 with wdata = 0x1234 -> mem_wmask = 8'hC0, mem_wdata = 64'h1234_0000_0000_0000, mem_addr = 0x8000_0000.
//  - LW at 0x8000_0002 -> resp_err = 1 one cycle after the handshake; mem_req_valid never asserts.
//  - mem_req_ready low for 5 cycles, resp_ready low for 3 cycles -> mem_* and resp_* outputs stay stable throughout; exactly one transaction completes.
//  - TIMEOUT = 4 with no mem_resp_valid -> resp_err = 1 after 4 WAIT cycles; a later mem_resp_valid has no effect.
//  - reset asserted in WAIT -> next cycle req_ready = 1 and resp_valid = 0; a following LD completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response and data-memory port of the load/store unit.
// The LSU uses the slave view; the surrounding pipeline and memory use the master view.
interface lsu_mem_ctrl_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wen;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [XLEN-1:0]   req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [XLEN-1:0]   mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_resp_err;

  modport slave (
    input  req_valid, req_addr, req_wen, req_size, req_signed, req_wdata,
    input  resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output req_valid, req_addr, req_wen, req_size, req_signed, req_wdata,
    output resp_ready,
    output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Sequential load/store unit: one access at a time, aligned byte-masked memory port,
// size/sign-extended load data, misalignment and bus-timeout errors.
module lsu_mem_ctrl #(
  parameter int XLEN    = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset,
  lsu_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  // Counter only has to reach TIMEOUT-1: the timeout fires on the last WAIT cycle.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [2:0]        off;
  logic              misaligned_in;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_ext;
  logic [7:0]        size_mask;

  always_comb begin
    off = addr_q[2:0];
    unique case (bus.req_size)
      2'd0:    misaligned_in = 1'b0;
      2'd1:    misaligned_in = bus.req_addr[0];
      2'd2:    misaligned_in = |bus.req_addr[1:0];
      default: misaligned_in = |bus.req_addr[2:0];
    endcase

    shifted = bus.mem_rdata >> {off, 3'b000};
    unique case (size_q)
      2'd0: begin
        load_ext  = {{(XLEN-8){sgn_q & shifted[7]}}, shifted[7:0]};
        size_mask = 8'h01;
      end
      2'd1: begin
        load_ext  = {{(XLEN-16){sgn_q & shifted[15]}}, shifted[15:0]};
        size_mask = 8'h03;
      end
      2'd2: begin
        load_ext  = {{(XLEN-32){sgn_q & shifted[31]}}, shifted[31:0]};
        size_mask = 8'h0F;
      end
      default: begin
        load_ext  = shifted;
        size_mask = 8'hFF;
      end
    endcase
  end

  // NOTE: every next-state signal gets its hold value first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        addr_d  = bus.req_addr;
        wen_d   = bus.req_wen;
        size_d  = bus.req_size;
        sgn_d   = bus.req_signed;
        wdata_d = bus.req_wdata;
        rdata_d = '0;
        err_d   = misaligned_in;
        state_d = misaligned_in ? S_RESP : S_REQ;
      end
      S_REQ: if (bus.mem_req_ready) begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_resp_valid) begin
          err_d   = bus.mem_resp_err;
          rdata_d = (wen_q || bus.mem_resp_err) ? '0 : load_ext;
          state_d = S_RESP;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: if (bus.resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      size_q  <= 2'd0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  logic in_req;
  assign in_req = (state_q == S_REQ);

  assign bus.req_ready     = (state_q == S_IDLE);
  assign bus.resp_valid    = (state_q == S_RESP);
  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_err      = err_q;
  assign bus.mem_req_valid = in_req;
  assign bus.mem_addr      = in_req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign bus.mem_wen       = in_req & wen_q;
  assign bus.mem_wdata     = in_req ? (wdata_q << {off, 3'b000}) : '0;
  assign bus.mem_wmask     = (in_req && wen_q) ? (size_mask << off) : 8'h00;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: alignment, extension, masks, stalls, timeout, reset.
module tb_lsu_mem_ctrl;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  lsu_mem_ctrl_if #(.XLEN(64), .ADDR_W(64)) bus ();

  lsu_mem_ctrl #(.XLEN(64), .ADDR_W(64), .TIMEOUT(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] addr, input logic wen, input logic [1:0] size,
                       input logic sgn, input logic [63:0] wdata);
    check("req_ready_before_issue", 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_wen    = wen;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_wdata  = wdata;
    tick();
    bus.req_valid  = 1'b0;
  endtask

  // Accept in REQ, let one WAIT cycle pass, then pulse the response.
  task automatic mem_complete(input logic [63:0] rdata, input logic err);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = rdata;
    bus.mem_resp_err   = err;
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_err   = 1'b0;
  endtask

  task automatic take_resp();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check("idle_after_resp", 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    rst                = 1'b1;
    bus.req_valid      = 1'b0;
    bus.req_addr       = '0;
    bus.req_wen        = 1'b0;
    bus.req_size       = 2'd0;
    bus.req_signed     = 1'b0;
    bus.req_wdata      = '0;
    bus.resp_ready     = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    bus.mem_resp_err   = 1'b0;
    tick();
    tick();

    check("rst_req_ready",     64'(bus.req_ready),     64'd1);
    check("rst_resp_valid",    64'(bus.resp_valid),    64'd0);
    check("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("rst_resp_rdata",    bus.resp_rdata,         64'd0);
    check("rst_resp_err",      64'(bus.resp_err),      64'd0);
    check("rst_mem_addr",      bus.mem_addr,           64'd0);
    check("rst_mem_wmask",     64'(bus.mem_wmask),     64'd0);
    rst = 1'b0;
    tick();

    // LB signed at offset 3; best-case latency is three cycles.
    issue(64'h8000_0003, 1'b0, 2'd0, 1'b1, 64'd0);
    check("lb_mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
    check("lb_mem_addr",      bus.mem_addr,           64'h8000_0000);
    check("lb_mem_wmask",     64'(bus.mem_wmask),     64'h00);
    check("lb_mem_wen",       64'(bus.mem_wen),       64'd0);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    check("lb_wait_no_req",   64'(bus.mem_req_valid), 64'd0);
    tick();
    check("lb_not_yet_resp",  64'(bus.resp_valid),    64'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 64'h0000_0000_80FF_0000;
    tick();
    bus.mem_resp_valid = 1'b0;
    check("lb_resp_valid",    64'(bus.resp_valid),    64'd1);
    check("lb_resp_rdata",    bus.resp_rdata,         64'hFFFF_FFFF_FFFF_FF80);
    check("lb_resp_err",      64'(bus.resp_err),      64'd0);
    take_resp();
    check("lb_idle_resp_low", 64'(bus.resp_valid),    64'd0);

    // SH at offset 6: upper two byte lanes.
    issue(64'h8000_0006, 1'b1, 2'd1, 1'b0, 64'h1234);
    check("sh_mem_wmask", 64'(bus.mem_wmask), 64'hC0);
    check("sh_mem_wdata", bus.mem_wdata,      64'h1234_0000_0000_0000);
    check("sh_mem_addr",  bus.mem_addr,       64'h8000_0000);
    check("sh_mem_wen",   64'(bus.mem_wen),   64'd1);
    mem_complete(64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    check("sh_resp_rdata", bus.resp_rdata,       64'd0);
    check("sh_resp_err",   64'(bus.resp_err),    64'd0);
    take_resp();

    // LW misaligned: error one cycle after handshake, no memory access.
    issue(64'h8000_0002, 1'b0, 2'd2, 1'b1, 64'd0);
    check("lw_mis_resp_valid", 64'(bus.resp_valid),    64'd1);
    check("lw_mis_resp_err",   64'(bus.resp_err),      64'd1);
    check("lw_mis_rdata",      bus.resp_rdata,         64'd0);
    check("lw_mis_no_mem",     64'(bus.mem_req_valid), 64'd0);
    tick();
    check("lw_mis_no_mem_2",   64'(bus.mem_req_valid), 64'd0);
    take_resp();

    // LW signed at offset 4 and LHU at offset 2.
    issue(64'h0000_1004, 1'b0, 2'd2, 1'b1, 64'd0);
    mem_complete(64'h8765_4321_0000_0000, 1'b0);
    check("lw_sext_rdata", bus.resp_rdata, 64'hFFFF_FFFF_8765_4321);
    take_resp();
    issue(64'h0000_1002, 1'b0, 2'd1, 1'b0, 64'd0);
    mem_complete(64'h0000_0000_F00D_0000, 1'b0);
    check("lhu_zext_rdata", bus.resp_rdata, 64'h0000_0000_0000_F00D);
    take_resp();

    // Bus error on an LD: err set, rdata forced to zero.
    issue(64'h0000_0018, 1'b0, 2'd3, 1'b0, 64'd0);
    mem_complete(64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
    check("ld_buserr_err",   64'(bus.resp_err), 64'd1);
    check("ld_buserr_rdata", bus.resp_rdata,    64'd0);
    take_resp();

    // SD with memory stalling 5 cycles and core stalling 3 cycles.
    issue(64'h8000_0008, 1'b1, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 5; i++) begin
      check("sd_stall_valid", 64'(bus.mem_req_valid), 64'd1);
      check("sd_stall_addr",  bus.mem_addr,           64'h8000_0008);
      check("sd_stall_wdata", bus.mem_wdata,          64'h0123_4567_89AB_CDEF);
      check("sd_stall_wmask", 64'(bus.mem_wmask),     64'hFF);
      tick();
    end
    mem_complete(64'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("sd_hold_valid", 64'(bus.resp_valid), 64'd1);
      check("sd_hold_err",   64'(bus.resp_err),   64'd0);
      check("sd_hold_rdata", bus.resp_rdata,      64'd0);
      tick();
    end
    take_resp();
    tick();
    check("sd_single_txn", 64'(bus.mem_req_valid), 64'd0);

    // Timeout after 4 WAIT cycles; a late response is ignored.
    issue(64'h0000_0100, 1'b0, 2'd3, 1'b0, 64'd0);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_still_waiting", 64'(bus.resp_valid), 64'd0);
    end
    tick();
    check("to_resp_valid", 64'(bus.resp_valid), 64'd1);
    check("to_resp_err",   64'(bus.resp_err),   64'd1);
    check("to_resp_rdata", bus.resp_rdata,      64'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 64'h5555_5555_5555_5555;
    bus.mem_resp_err   = 1'b0;
    tick();
    bus.mem_resp_valid = 1'b0;
    check("to_late_err",   64'(bus.resp_err), 64'd1);
    check("to_late_rdata", bus.resp_rdata,    64'd0);
    take_resp();
    bus.mem_resp_valid = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    check("idle_resp_ignored", 64'(bus.resp_valid), 64'd0);

    // Reset while in WAIT, then a normal LD.
    issue(64'h0000_0200, 1'b0, 2'd3, 1'b0, 64'd0);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_wait_req_ready",  64'(bus.req_ready),     64'd1);
    check("rst_wait_resp_valid", 64'(bus.resp_valid),    64'd0);
    check("rst_wait_mem_valid",  64'(bus.mem_req_valid), 64'd0);
    issue(64'h0000_0208, 1'b0, 2'd3, 1'b1, 64'd0);
    check("ld_after_rst_addr", bus.mem_addr, 64'h0000_0208);
    mem_complete(64'h1122_3344_5566_7788, 1'b0);
    check("ld_after_rst_rdata", bus.resp_rdata,    64'h1122_3344_5566_7788);
    check("ld_after_rst_err",   64'(bus.resp_err), 64'd0);
    take_resp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
